sradd_iter: RTL

Multi-cycle single-precision (IEEE-754 layout) adder/subtractor with valid/ready handshakes on both sides: z = a + b, or z = a - b when sub=1. It is the sequential, handshaked counterpart to the combinational SP add/sub units and is used by FFT butterfly control where throughput per lane is low and area matters. Normalisation shifts one bit per cycle, so latency is data-dependent. Numeric conventions match the existing SP blocks:
- truncation, no rounding
- no denormals
- zero on underflow
- 32'hFFFFFFFF ("NaN") on overflow

---
 rtl/fp_sp_pkg.sv | 29 ++
 rtl/sp_align_shift.sv | 70 +++++++
 rtl/sradd_iter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/fp_sp_pkg.sv
// Shared single-precision helpers for the SP datapath blocks.
// Holds the IEEE-754 field positions, the special result encodings, the
// FSM state encoding of the iterative adder, and a field packing helper.
package fp_sp_pkg;

    localparam int SIGN    = 31;
    localparam int EXP_HI  = 30;
    localparam int EXP_LO  = 23;
    localparam int MANT_HI = 22;
    localparam int MANT_LO = 0;

    localparam logic [31:0] FP_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP_NAN  = 32'hFFFF_FFFF;
    localparam logic [7:0]  EXP_INF = 8'hFF;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        DONE  = 3'd4
    } state_t;

    function automatic logic [31:0] pack_fp(input logic s, input logic [7:0] e,
                                            input logic [22:0] m);
        return {s, e, m};
    endfunction

endpackage

// File: rtl/sp_align_shift.sv
// Combinational alignment stage of the iterative SP adder.
// Ports:
//   a_i, b_i     : latched SP operands
//   bs_i         : effective sign of b (b[31] ^ sub)
//   special_o    : result is fully decided here (NaN, zero, pass-through)
//   special_z_o  : that decided result
//   swap_o       : 1 when |b| > |a| (b is the larger-magnitude operand)
//   m_big_o      : 24-bit mantissa (hidden one restored) of the larger operand
//   m_small_o    : smaller operand mantissa shifted right by the exponent gap
//   ze_o         : exponent of the larger operand
module sp_align_shift
    import fp_sp_pkg::*;
#(
    parameter int MAX_EDIFF = 24
) (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        bs_i,
    output logic        special_o,
    output logic [31:0] special_z_o,
    output logic        swap_o,
    output logic [23:0] m_big_o,
    output logic [23:0] m_small_o,
    output logic [7:0]  ze_o
);

    localparam logic [7:0] MAX_EDIFF_U = 8'(MAX_EDIFF);

    logic [7:0]  ea, eb, e_big, e_small, ediff;
    logic [22:0] fa, fb;
    logic [23:0] m_small_full;
    logic [31:0] a_eff, b_eff;

    always_comb begin
        ea    = a_i[EXP_HI:EXP_LO];
        eb    = b_i[EXP_HI:EXP_LO];
        fa    = a_i[MANT_HI:MANT_LO];
        fb    = b_i[MANT_HI:MANT_LO];
        a_eff = a_i;
        b_eff = {bs_i, b_i[EXP_HI:MANT_LO]};

        // Magnitude order: exponent first, mantissa breaks ties; a wins equality.
        swap_o       = ({eb, fb} > {ea, fa});
        e_big        = swap_o ? eb : ea;
        e_small      = swap_o ? ea : eb;
        m_big_o      = {1'b1, (swap_o ? fb : fa)};
        m_small_full = {1'b1, (swap_o ? fa : fb)};
        ediff        = e_big - e_small;
        // Gaps of 24 and above shift the whole mantissa out (truncation).
        m_small_o    = m_small_full >> ediff;
        ze_o         = e_big;

        special_o   = 1'b1;
        special_z_o = FP_ZERO;
        if (ea == EXP_INF || eb == EXP_INF) begin
            special_z_o = FP_NAN;
        end else if (ea == 8'd0 && eb == 8'd0) begin
            special_z_o = FP_ZERO;
        end else if (ea == 8'd0) begin
            special_z_o = b_eff;
        end else if (eb == 8'd0) begin
            special_z_o = a_eff;
        end else if (ediff > MAX_EDIFF_U) begin
            special_z_o = swap_o ? b_eff : a_eff;
        end else begin
            special_o = 1'b0;
        end
    end

endmodule

// File: rtl/sradd_iter.sv
// Iterative single-precision adder/subtractor with valid/ready handshakes.
// z = a + b (sub=0) or a - b (sub=1); truncating, no denormals, zero on
// underflow, all-ones on overflow or Inf/NaN input. Normalisation shifts
// one bit per cycle, so latency depends on the amount of cancellation.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   in_valid / in_ready   : operand handshake (ready only while idle)
//   a, b, sub             : SP operands and operation select
//   out_valid / out_ready : result handshake; z held until accepted
//   z                     : SP result
module sradd_iter
    import fp_sp_pkg::*;
#(
    parameter int MAX_EDIFF = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] z
);

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d, b_q, b_d, z_q, z_d;
    logic        bs_q, bs_d;
    logic [23:0] ma_q, ma_d, mb_q, mb_d;
    logic [7:0]  ze_q, ze_d;
    logic        sign_q, sign_d;
    logic        eff_sub_q, eff_sub_d;
    logic        out_valid_q, out_valid_d;

    logic        al_special, al_swap;
    logic [31:0] al_z;
    logic [23:0] al_m_big, al_m_small;
    logic [7:0]  al_ze;
    logic [24:0] sum_w;

    sp_align_shift #(
        .MAX_EDIFF (MAX_EDIFF)
    ) u_align (
        .a_i         (a_q),
        .b_i         (b_q),
        .bs_i        (bs_q),
        .special_o   (al_special),
        .special_z_o (al_z),
        .swap_o      (al_swap),
        .m_big_o     (al_m_big),
        .m_small_o   (al_m_small),
        .ze_o        (al_ze)
    );

    // ma_q always holds the larger magnitude, so the difference never wraps.
    assign sum_w = eff_sub_q ? ({1'b0, ma_q} - {1'b0, mb_q})
                             : ({1'b0, ma_q} + {1'b0, mb_q});

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign z         = z_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            bs_q        <= 1'b0;
            ma_q        <= '0;
            mb_q        <= '0;
            ze_q        <= '0;
            sign_q      <= 1'b0;
            eff_sub_q   <= 1'b0;
            z_q         <= FP_ZERO;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            bs_q        <= bs_d;
            ma_q        <= ma_d;
            mb_q        <= mb_d;
            ze_q        <= ze_d;
            sign_q      <= sign_d;
            eff_sub_q   <= eff_sub_d;
            z_q         <= z_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        bs_d        = bs_q;
        ma_d        = ma_q;
        mb_d        = mb_q;
        ze_d        = ze_q;
        sign_d      = sign_q;
        eff_sub_d   = eff_sub_q;
        z_d         = z_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    bs_d    = b[SIGN] ^ sub;
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                if (al_special) begin
                    z_d     = al_z;
                    state_d = DONE;
                end else begin
                    ma_d      = al_m_big;
                    mb_d      = al_m_small;
                    ze_d      = al_ze;
                    sign_d    = al_swap ? bs_q : a_q[SIGN];
                    eff_sub_d = a_q[SIGN] ^ bs_q;
                    state_d   = ADD;
                end
            end
            ADD: begin
                if (sum_w == 25'd0) begin
                    z_d     = FP_ZERO;
                    state_d = DONE;
                end else if (sum_w[24]) begin
                    if (ze_q == 8'd254) begin
                        z_d     = FP_NAN;
                        state_d = DONE;
                    end else begin
                        ma_d    = sum_w[24:1];
                        ze_d    = ze_q + 8'd1;
                        state_d = NORM;
                    end
                end else begin
                    ma_d    = sum_w[23:0];
                    state_d = NORM;
                end
            end
            NORM: begin
                if (ma_q[23]) begin
                    z_d     = pack_fp(sign_q, ze_q, ma_q[22:0]);
                    state_d = DONE;
                end else begin
                    ma_d = {ma_q[22:0], 1'b0};
                    ze_d = ze_q - 8'd1;
                    // Exponent would reach zero: no denormals, flush to +0.
                    if (ze_q == 8'd1) begin
                        z_d     = FP_ZERO;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // out_valid rises one edge after entering DONE, then holds
                // until the consumer takes the result.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
